// File: rtl/bit_serializer_if.sv
// Parallel-load handshake between an upstream word source and bit_serializer.
// A word transfers on a rising edge where load_valid and load_ready are both high.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (output load_data, output load_valid, input load_ready);
  modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word hold register, so back-to-back words
// stream without gaps. Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit per word.
//
// Handshake: load_ready comes only from registered state (hold register empty) and
// never looks at load_valid. The upstream keeps load_valid and load_data stable until
// it sees load_ready high on a rising edge. A word offered while load_ready is low is
// not captured.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  load,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
`ifdef BIT_SERIALIZER_PARITY_EN
    ,
    S_PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             take;
  logic             finish;
  logic             start;
  logic [WIDTH-1:0] start_word;

  assign load.load_ready = ~hold_full_q;
  assign take            = load.load_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    x_valid_d   = x_valid_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    finish      = 1'b0;
    start       = 1'b0;
    start_word  = '0;

    // cnt_q counts data bits still to come after the one currently on x.
    case (state_q)
      S_IDLE: begin
        if (take) begin
          start      = 1'b1;
          start_word = load.load_data;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (MSB_FIRST) begin
            x_d     = shift_q[WIDTH-1];
            shift_d = shift_q << 1;
          end else begin
            x_d     = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          x_d     = parity_q;
          state_d = S_PARITY;
`else
          finish  = 1'b1;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      S_PARITY: begin
        finish = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // At the end of a frame the next word comes from the hold register first, then
    // straight from the bus, so consecutive frames abut.
    if (finish) begin
      if (hold_full_q) begin
        start       = 1'b1;
        start_word  = hold_q;
        hold_full_d = 1'b0;
      end else if (take) begin
        start      = 1'b1;
        start_word = load.load_data;
      end else begin
        state_d   = S_IDLE;
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
      end
    end else if (take && (state_q != S_IDLE)) begin
      hold_d      = load.load_data;
      hold_full_d = 1'b1;
    end

    if (start) begin
      state_d   = S_SHIFT;
      x_valid_d = 1'b1;
      cnt_d     = CW'(WIDTH - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_d  = ^start_word;
`endif
      if (MSB_FIRST) begin
        x_d     = start_word[WIDTH-1];
        shift_d = start_word << 1;
      end else begin
        x_d     = start_word[0];
        shift_d = start_word >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      x_q         <= IDLE_BIT;
      x_valid_q   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = (state_q != S_IDLE) | hold_full_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance,
// with hand-written bit sequences and a per-bit expected queue for streamed words.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  bit_serializer_if #(.WIDTH(W)) ifa ();
  bit_serializer_if #(.WIDTH(W)) ifb ();

  logic       xa, xva, busya;
  logic [1:0] sta;
  logic       xb, xvb, busyb;
  logic [1:0] stb;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .load(ifa),
    .x(xa), .x_valid(xva), .busy(busya), .dbg_state(sta)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .load(ifb),
    .x(xb), .x_valid(xvb), .busy(busyb), .dbg_state(stb)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];
  logic [7:0] words[4];
  int         offs[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected emission of one word on the MSB-first instance.
  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < W; i++) exp_q.push_back(w[W-1-i]);
`ifdef BIT_SERIALIZER_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One word from idle, checked bit by bit against a hand-written sequence.
  // seq[8] is the first bit on x; seq[0] is the parity bit (used only with parity).
  task automatic hand_run(input bit sel_b, input logic [7:0] w, input logic [8:0] seq,
                          input string tag);
    check_eq({tag, "_rdy"}, sel_b ? ifb.load_ready : ifa.load_ready, 1);
    if (sel_b) begin ifb.load_valid = 1'b1; ifb.load_data = w; end
    else       begin ifa.load_valid = 1'b1; ifa.load_data = w; end
    @(negedge clk);
    ifa.load_valid = 1'b0;
    ifb.load_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      check_eq({tag, "_bit"}, sel_b ? {xvb, xb} : {xva, xa}, {1'b1, seq[8-i]});
      if (i == 0) check_eq({tag, "_busy"}, sel_b ? busyb : busya, 1);
      @(negedge clk);
    end
    check_eq({tag, "_idle"}, sel_b ? {xvb, xb} : {xva, xa}, 2'b00);
    check_eq({tag, "_busy_end"}, sel_b ? busyb : busya, 0);
  endtask

  // Streams nw words (words[], each offered from cycle offs[k]) on instance A,
  // with load_valid held until accepted; checks every emitted bit from exp_q.
  task automatic run_a(input int nw, input int rdy_cyc, input logic rdy_exp, input string tag);
    int         idx;
    int         cyc;
    int         nvalid;
    logic       offered;
    logic       rdy_prev;
    logic [0:0] eb;
    idx = 0; cyc = 0; nvalid = 0; offered = 1'b0; rdy_prev = 1'b0;
    while (((idx < nw) || (exp_q.size() > 0)) && (cyc < 300)) begin
      if (offered && rdy_prev) begin
        push_word(words[idx]);
        idx++;
      end
      if (exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        check_eq({tag, "_bit"}, {xva, xa}, {1'b1, eb});
      end
      if (xva) nvalid++;
      if (cyc == rdy_cyc) check_eq({tag, "_rdy"}, ifa.load_ready, rdy_exp);
      offered        = (idx < nw) && (cyc >= offs[idx]);
      ifa.load_valid = offered;
      ifa.load_data  = offered ? words[idx] : 8'h00;
      rdy_prev       = ifa.load_ready;
      @(negedge clk);
      cyc++;
    end
    ifa.load_valid = 1'b0;
    check_eq({tag, "_done"}, cyc < 300, 1);
    check_eq({tag, "_nbits"}, nvalid, nw * FRAME);
    check_eq({tag, "_idle"}, {xva, xa}, 2'b00);
  endtask

  // ---------------- main sequence ----------------
  int nseen;

  initial begin
    ifa.load_valid = 1'b0; ifa.load_data = '0;
    ifb.load_valid = 1'b0; ifb.load_data = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_x",     xa, 0);
    check_eq("rst_xv",    xva, 0);
    check_eq("rst_rdy",   ifa.load_ready, 1);
    check_eq("rst_busy",  busya, 0);
    check_eq("rst_state", sta, 0);
    check_eq("rst_rdy_b", ifb.load_ready, 1);
    reset = 1'b1;

    // First word offered on the very first edge after reset release.
    hand_run(1'b0, 8'hA5, {8'b10100101, 1'b0}, "a5");
    hand_run(1'b1, 8'h0A, {8'b01010000, 1'b0}, "b0a");

    // Consecutive loads: second word lands in the hold register.
    words[0] = 8'hAA; words[1] = 8'h55; offs[0] = 0; offs[1] = 0;
    run_a(2, 2, 1'b0, "b2b");

    // load_valid held high for four words.
    words[0] = 8'h3C; words[1] = 8'hF0; words[2] = 8'h81; words[3] = 8'h6E;
    offs[0] = 0; offs[1] = 0; offs[2] = 0; offs[3] = 0;
    run_a(4, FRAME + 1, 1'b1, "cont4");

    // Second word arrives exactly on the completing edge: straight into the shifter.
    words[0] = 8'hC3; words[1] = 8'h5A; offs[0] = 0; offs[1] = FRAME;
    run_a(2, FRAME + 1, 1'b1, "direct");

    // Parity vectors (parity bit only emitted in the parity build).
    hand_run(1'b0, 8'h07, {8'b00000111, 1'b1}, "p07");
    hand_run(1'b0, 8'h03, {8'b00000011, 1'b0}, "p03");

    // Reset mid-stream with the hold register full.
    ifa.load_valid = 1'b1; ifa.load_data = 8'hFF;
    @(negedge clk);
    ifa.load_data = 8'h0F;
    @(negedge clk);
    ifa.load_valid = 1'b0;
    check_eq("mid_hold_rdy", ifa.load_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_x",     xa, 0);
    check_eq("mid_rst_xv",    xva, 0);
    check_eq("mid_rst_rdy",   ifa.load_ready, 1);
    check_eq("mid_rst_busy",  busya, 0);
    check_eq("mid_rst_state", sta, 0);
    @(negedge clk);
    reset = 1'b1;
    nseen = 0;
    repeat (2 * FRAME + 2) begin
      @(negedge clk);
      if (xva) nseen++;
    end
    check_eq("mid_no_partial", nseen, 0);

    words[0] = 8'h3C; offs[0] = 0;
    run_a(1, 0, 1'b1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per loaded word.
REQ-002 Parameter MSB_FIRST, default 1: 1 emits bit WIDTH-1 first; 0 emits bit 0 first.
REQ-003 Parameter IDLE_BIT, default 0: level driven on x while no word is being emitted.
REQ-004 Port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port load_data  input  WIDTH  parallel word to serialize.
REQ-007 Port load_valid  input  1  load_data is valid this cycle.
REQ-008 Port load_ready  output  1  block can accept a word this cycle.
REQ-009 Port x  output  1  registered serial bit stream, one bit per clock; feeds the downstream sequence detector's x input.
REQ-010 Port x_valid  output  1  x carries a data bit (or parity bit) this cycle, not idle fill.
REQ-011 Port busy  output  1  shifter or hold register occupied.

Function
REQ-012 Storage: one shift register (WIDTH bits), one hold register (WIDTH bits, full flag), bit counter of clog2(WIDTH+1) bits.
REQ-013 States: IDLE (shifter empty), SHIFT (emitting data bits), PARITY (emitting parity bit, only when configured).
REQ-014 load_ready = NOT hold_full, combinational from registered state only; never depends on load_valid.
REQ-015 Transfer occurs on a rising edge with load_valid=1 and load_ready=1; load_data is sampled at that edge.
REQ-016 Transfer in IDLE: word goes directly to the shifter; first bit appears on x in the following cycle (latency 1 clock); state -> SHIFT.
REQ-017 Transfer in SHIFT/PARITY: word goes into the hold register, unless the shifter completes on that same edge, in which case it goes directly into the shifter.
REQ-018 SHIFT emits exactly WIDTH bits on consecutive cycles, in the order set by MSB_FIRST, with x_valid=1.
REQ-019 On completion of the last bit (or parity bit): hold full -> hold moves to shifter, hold_full clears, next word's first bit follows with no gap; hold empty and no transfer -> IDLE.
REQ-020 In IDLE: x = IDLE_BIT, x_valid = 0.
REQ-021 load_valid while load_ready=0 is ignored; the data is not captured and the upstream holds it.
REQ-022 busy = (state != IDLE) OR hold_full.

Reset
REQ-023 reset low asynchronously forces: state IDLE, x=IDLE_BIT, x_valid=0, hold_full=0, bit counter 0, load_ready=1, busy=0.
REQ-024 Reset asserted mid-word discards the shifter and hold contents; no partial bits are emitted after release.
REQ-025 First transfer is possible on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro BIT_SERIALIZER_PARITY_EN defined: after each word's WIDTH data bits, one PARITY cycle emits the even parity (XOR of the word) with x_valid=1; frame length is WIDTH+1.
REQ-027 Macro undefined: PARITY state absent; frames are WIDTH bits; back-to-back words abut directly.

Verification
REQ-028 Reset low mid-stream -> x=0, x_valid=0, load_ready=1 immediately, before the next clock edge.
REQ-029 WIDTH=8, MSB_FIRST=1, load 0xA5 from IDLE -> x = 1,0,1,0,0,1,0,1 in the next 8 cycles, x_valid=1, then x=0, x_valid=0.
REQ-030 MSB_FIRST=0, load 0x0A -> x = 0,1,0,1,0,0,0,0; the detector downstream sees 1010 at bits 1-4 (with the preceding 0).
REQ-031 Loads 0xAA then 0x55 issued on consecutive cycles -> load_ready low for the second cycle after the hold fills; output is 16 contiguous bits 10101010 01010101 with no idle gap.
REQ-032 load_valid held high continuously for 4 words -> exactly 4 transfers, 32 contiguous valid bits, no word dropped or duplicated.
REQ-033 BIT_SERIALIZER_PARITY_EN defined, load 0x07 -> 8 data bits then parity bit 1; load 0x03 -> parity bit 0.
